// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with count, almost-full/empty flags and overflow/underflow pulses.
// Optional first-word fall-through read port when SYNC_FIFO_FWFT_EN is defined.
module sync_fifo_param #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         rd_en,
  output logic [WIDTH-1:0]             data_out,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_acc;
  logic             rd_acc;

  always_comb begin
    full         = (count == CW'(DEPTH));
    empty        = (count == '0);
    almost_full  = (count >= CW'(AF_LEVEL));
    almost_empty = (count <= CW'(AE_LEVEL));
    wr_acc       = wr_en && !full;
    rd_acc       = rd_en && !empty;
  end

  // Storage is deliberately not reset; empty masks stale entries.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is presented combinationally; zero while empty keeps the reset value clean.
  always_comb begin
    data_out = empty ? '0 : mem[rd_ptr];
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (rd_acc) begin
      data_out <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: accepted writes are queued, accepted reads are popped and compared.
// Honours SYNC_FIFO_FWFT_EN to choose the read-port model.
module tb_sync_fifo_param;

  localparam int unsigned W   = 4;
  localparam int unsigned D   = 8;
  localparam int unsigned AF  = 6;
  localparam int unsigned AE  = 2;
  localparam int unsigned CW  = $clog2(D+1);

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [W-1:0]  data_in;
  logic          rd_en;
  logic [W-1:0]  data_out;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;

  sync_fifo_param #(
    .WIDTH   (W),
    .DEPTH   (D),
    .AF_LEVEL(AF),
    .AE_LEVEL(AE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .data_in     (data_in),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned  n_vec = 0;
  int unsigned  n_err = 0;
  logic [W-1:0] sb_q[$];
  logic [W-1:0] exp_dout = '0;
  logic         exp_ovf  = 1'b0;
  logic         exp_unf  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    int unsigned n;
    n = sb_q.size();
    check_val("count",        32'(count),        32'(n));
    check_val("full",         32'(full),         32'(n == D));
    check_val("empty",        32'(empty),        32'(n == 0));
    check_val("almost_full",  32'(almost_full),  32'(n >= AF));
    check_val("almost_empty", 32'(almost_empty), 32'(n <= AE));
    check_val("overflow",     32'(overflow),     32'(exp_ovf));
    check_val("underflow",    32'(underflow),    32'(exp_unf));
`ifdef SYNC_FIFO_FWFT_EN
    if (n != 0) check_val("fwft_head", 32'(data_out), 32'(sb_q[0]));
`else
    check_val("data_out", 32'(data_out), 32'(exp_dout));
`endif
  endtask

  // One clock: drive at negedge, update the scoreboard from pre-edge state, check after the edge.
  task automatic step(input logic w, input logic [W-1:0] d, input logic r);
    logic was_full, was_empty;
    @(negedge clk);
    wr_en = w; data_in = d; rd_en = r;
    was_full  = (sb_q.size() == D);
    was_empty = (sb_q.size() == 0);
    exp_ovf = w && was_full;
    exp_unf = r && was_empty;
    if (r && !was_empty) exp_dout = sb_q.pop_front();
    if (w && !was_full)  sb_q.push_back(d);
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] wrap_vals [8];
    wrap_vals = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'h3, 4'h4, 4'h5};
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_state();
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-stream
    step(1'b1, 4'h1, 1'b0);
    step(1'b1, 4'h2, 1'b0);
    step(1'b1, 4'h3, 1'b0);
    step(1'b0, '0, 1'b1);
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    #2 rst_n = 1'b0;
    sb_q.delete(); exp_dout = '0; exp_ovf = 1'b0; exp_unf = 1'b0;
    #1;
    check_state();
    check_val("rst_data_out", 32'(data_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill, then an overflow attempt
    for (int unsigned i = 1; i <= D; i++) step(1'b1, W'(i), 1'b0);
    step(1'b1, 4'hF, 1'b0);
    idle();

    // Drain, then an underflow attempt
    for (int unsigned i = 0; i < D; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    idle();

    // Pointer wrap-around
    for (int unsigned i = 0; i < 5; i++) step(1'b1, W'(i + 6), 1'b0);
    for (int unsigned i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
    for (int unsigned i = 0; i < 8; i++) step(1'b1, wrap_vals[i], 1'b0);
    for (int unsigned i = 0; i < 8; i++) step(1'b0, '0, 1'b1);

    // Simultaneous push/pop at mid occupancy
    for (int unsigned i = 0; i < 4; i++) step(1'b1, W'(i + 1), 1'b0);
    for (int unsigned i = 0; i < 10; i++) step(1'b1, W'($urandom), 1'b1);
    // Simultaneous at full
    for (int unsigned i = 0; i < 4; i++) step(1'b1, W'(i + 9), 1'b0);
    step(1'b1, 4'h7, 1'b1);
    // Simultaneous at empty
    while (sb_q.size() != 0) step(1'b0, '0, 1'b1);
    step(1'b1, 4'h9, 1'b1);
    idle();
    step(1'b0, '0, 1'b1);
    idle();

    // Random traffic
    for (int unsigned i = 0; i < 300; i++)
      step(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 2) == 0) || (i >= 150 && $urandom_range(0, 1) == 1));
    while (sb_q.size() != 0) step(1'b0, '0, 1'b1);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
